vhdci_cmd_rx: RTL and testbench

Command deframer on the receive side of the VHDCI serial link. Sits directly downstream of the link mux and consumes its 7-bit parallel receive word and its link-synced flag. Reassembles 5-symbol frames into 8-bit-address / 16-bit-data register write commands, verifies a 6-bit XOR checksum, and presents each command on a one-entry valid/ready output. Frame health counters feed status and debug registers.

---
 rtl/vhdci_cmd_rx.sv | 97 +++++++++
 tb/tb_vhdci_cmd_rx.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/vhdci_cmd_rx.sv
// Receive-side command deframer for the VHDCI link: rebuilds 5-symbol frames into
// address/data write commands, checks the XOR checksum, and tracks frame health.
module vhdci_cmd_rx #(
  parameter int CNT_W = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [6:0]       mux_data_in,
  input  logic             mux_synced,
  output logic             wr_valid,
  input  logic             wr_ready,
  output logic [7:0]       wr_addr,
  output logic [15:0]      wr_data,
  output logic [15:0]      frame_cnt,
  output logic [CNT_W-1:0] chk_err_cnt,
  output logic [CNT_W-1:0] abort_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic [2:0] {IDLE, F1, F2, F3, CHK} state_t;

  state_t      state;
  logic [23:0] payload;
  logic [5:0]  acc;
  logic        sof;
  logic [5:0]  sym;
  logic        good;
  logic        take;
  logic        load;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    sof  = mux_data_in[6];
    sym  = mux_data_in[5:0];
    good = mux_synced && (state == CHK) && !sof && (sym == acc);
    take = wr_valid && wr_ready;
    // A completing frame may reuse the slot freed by a same-cycle handshake.
    load = good && (!wr_valid || take);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state       <= IDLE;
      payload     <= '0;
      acc         <= '0;
      wr_valid    <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      frame_cnt   <= '0;
      chk_err_cnt <= '0;
      abort_cnt   <= '0;
      drop_cnt    <= '0;
    end else begin
      if (take)
        wr_valid <= 1'b0;
      if (load) begin
        wr_valid  <= 1'b1;
        wr_addr   <= payload[23:16];
        wr_data   <= payload[15:0];
        frame_cnt <= frame_cnt + 16'd1;
      end else if (good) begin
        drop_cnt <= sat_inc(drop_cnt);
      end

      if (!mux_synced) begin
        state <= IDLE;
        if (state != IDLE)
          abort_cnt <= sat_inc(abort_cnt);
      end else if (sof) begin
        // Any start marker begins a new frame; one arriving mid-frame aborts the old one.
        payload <= {18'd0, sym};
        acc     <= sym;
        state   <= F1;
        if (state != IDLE)
          abort_cnt <= sat_inc(abort_cnt);
      end else begin
        case (state)
          F1, F2, F3: begin
            payload <= {payload[17:0], sym};
            acc     <= acc ^ sym;
            state   <= (state == F1) ? F2 : (state == F2) ? F3 : CHK;
          end
          CHK: begin
            if (sym != acc)
              chk_err_cnt <= sat_inc(chk_err_cnt);
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vhdci_cmd_rx.sv
// Bench for vhdci_cmd_rx: scoreboard of expected commands popped on each handshake,
// plus counter checks after each scenario.
module tb_vhdci_cmd_rx;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [6:0]  mux_data_in = '0;
  logic        mux_synced = 1'b0;
  logic        wr_valid;
  logic        wr_ready = 1'b0;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic [15:0] frame_cnt;
  logic [7:0]  chk_err_cnt;
  logic [7:0]  abort_cnt;
  logic [7:0]  drop_cnt;

  int vectors = 0;
  int miscompares = 0;
  logic [23:0] sb_q[$];

  vhdci_cmd_rx #(.CNT_W(8)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .mux_data_in(mux_data_in),
    .mux_synced(mux_synced), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .frame_cnt(frame_cnt),
    .chk_err_cnt(chk_err_cnt), .abort_cnt(abort_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor: a presented command must match the scoreboard head.
  always @(negedge clk_in) begin
    if (!rst_in && wr_valid) begin
      if (sb_q.size() == 0)
        check("unexpected_cmd", {8'd0, wr_addr, wr_data}, 32'hFFFF_FFFF);
      else if (wr_ready)
        check("cmd", {8'd0, wr_addr, wr_data}, {8'd0, sb_q.pop_front()});
      else
        check("hold", {8'd0, wr_addr, wr_data}, {8'd0, sb_q[0]});
    end
  end

  task automatic drive(input logic [6:0] s, input logic sync);
    @(posedge clk_in); #1;
    mux_data_in = s;
    mux_synced  = sync;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(7'h00, 1'b1);
  endtask

  task automatic do_reset();
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    sb_q.delete();
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [15:0] d,
                            input logic bad, input logic push);
    logic [23:0] p;
    logic [5:0]  c;
    p = {a, d};
    c = p[23:18] ^ p[17:12] ^ p[11:6] ^ p[5:0];
    if (bad) c = ~c;
    drive({1'b1, p[23:18]}, 1'b1);
    drive({1'b0, p[17:12]}, 1'b1);
    drive({1'b0, p[11:6]}, 1'b1);
    drive({1'b0, p[5:0]}, 1'b1);
    if (push) sb_q.push_back(p);
    drive({1'b0, c}, 1'b1);
  endtask

  task automatic check_cnts(input string tag, input int f, input int c, input int a, input int dr);
    @(negedge clk_in);
    check({tag, "_frame"}, {16'd0, frame_cnt}, f);
    check({tag, "_chk"}, {24'd0, chk_err_cnt}, c);
    check({tag, "_abort"}, {24'd0, abort_cnt}, a);
    check({tag, "_drop"}, {24'd0, drop_cnt}, dr);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] good_tbl [5];
    good_tbl = '{7'h56, 7'h21, 7'h08, 7'h34, 7'h0B};

    // Reset state
    mux_synced = 1'b1;
    do_reset();
    @(negedge clk_in);
    check("rst_valid", {31'd0, wr_valid}, 0);
    check("rst_cmd", {8'd0, wr_addr, wr_data}, 0);
    check_cnts("rst", 0, 0, 0, 0);

    // Good frame from the literal table, latency one cycle after S4
    wr_ready = 1'b1;
    sb_q.push_back(24'h5A1234);
    for (int i = 0; i < 5; i++) drive(good_tbl[i], 1'b1);
    @(negedge clk_in);
    @(negedge clk_in);
    check("latency_valid", {31'd0, wr_valid}, 1);
    idle(3);
    check_cnts("good", 1, 0, 0, 0);
    check("good_single", {31'd0, wr_valid}, 0);

    // Bad checksum 0x0C
    do_reset();
    for (int i = 0; i < 4; i++) drive(good_tbl[i], 1'b1);
    drive(7'h0C, 1'b1);
    idle(3);
    check_cnts("badchk", 0, 1, 0, 0);

    // Abort and restart
    do_reset();
    drive(7'h56, 1'b1);
    drive(7'h21, 1'b1);
    sb_q.push_back(24'h5A1234);
    for (int i = 0; i < 5; i++) drive(good_tbl[i], 1'b1);
    idle(3);
    check_cnts("abort", 1, 0, 1, 0);

    // Back-to-back random frames at full rate, no drops
    do_reset();
    for (int i = 0; i < 8; i++)
      send_frame(8'($urandom), 16'($urandom), 1'b0, 1'b1);
    idle(3);
    check_cnts("b2b", 8, 0, 0, 0);

    // Backpressure: second frame dropped, first held
    do_reset();
    wr_ready = 1'b0;
    send_frame(8'hA5, 16'hBEEF, 1'b0, 1'b1);
    send_frame(8'h3C, 16'h0F0F, 1'b0, 1'b0);
    idle(4);
    check_cnts("bp", 1, 0, 0, 1);
    wr_ready = 1'b1;
    idle(4);
    check("bp_drained", {31'd0, wr_valid}, 0);
    check("bp_queue", sb_q.size(), 0);

    // Link loss mid-frame, in IDLE, and during the CHK cycle
    do_reset();
    drive(7'h56, 1'b1);
    drive(7'h21, 1'b1);
    drive(7'h08, 1'b0);
    idle(2);
    check_cnts("loss", 0, 0, 1, 0);
    drive(7'h56, 1'b0);
    idle(2);
    check_cnts("loss_idle", 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) drive(good_tbl[i], 1'b1);
    drive(7'h0B, 1'b0);
    idle(3);
    check_cnts("loss_chk", 0, 0, 2, 0);

    // Saturation of chk_err_cnt
    do_reset();
    for (int i = 0; i < 300; i++) send_frame(8'(i), 16'(i * 7), 1'b1, 1'b0);
    idle(2);
    check_cnts("sat", 0, 255, 0, 0);

    // Reset mid-frame with a command held
    do_reset();
    wr_ready = 1'b0;
    send_frame(8'h11, 16'h2233, 1'b0, 1'b1);
    drive(7'h56, 1'b1);
    drive(7'h21, 1'b1);
    drive(7'h08, 1'b1);
    do_reset();
    @(negedge clk_in);
    check("midrst_valid", {31'd0, wr_valid}, 0);
    check_cnts("midrst", 0, 0, 0, 0);
    wr_ready = 1'b1;
    drive(7'h0B, 1'b1);
    drive(7'h34, 1'b1);
    send_frame(8'hC3, 16'h55AA, 1'b0, 1'b1);
    idle(3);
    check_cnts("postrst", 1, 0, 0, 0);
    check("final_queue", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
